// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Purpose
//    Serial pattern detector. Accepted bits (in_valid=1) are shifted into a
//    PAT_LEN-1 bit history. The incoming bit completes a match when the
//    history is full and {history, in_seq} equals pattern, so det_out is a
//    Mealy pulse in the same cycle as the last pattern bit. Overlapping or
//    non-overlapping detection is chosen at run time with ovl_mode.
//
// Optional feature
//    SEQ_DET_COUNT_EN : when defined, det_count is a saturating count of
//                       detections. When undefined, det_count is tied to zero
//                       and no counter flops exist.
//
// Parameters
//    PAT_LEN : pattern length in bits (2..16)
//    CNT_W   : width of the detection counter
//
// Ports
//    clk       in   1        rising-edge clock
//    rst       in   1        asynchronous reset, active low
//    in_valid  in   1        qualifies in_seq
//    in_seq    in   1        serial data bit
//    pattern   in   PAT_LEN  target sequence, pattern[PAT_LEN-1] received first
//    ovl_mode  in   1        1 = overlapping, 0 = non-overlapping detection
//    clr       in   1        synchronous clear of history, fill and counter
//    det_out   out  1        combinational detect pulse
//    det_count out  CNT_W    saturating detection count (zero if disabled)
// -----------------------------------------------------------------------------
module seq_detect_param #(
   parameter int PAT_LEN = 3,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_seq,
   input  logic [PAT_LEN-1:0] pattern,
   input  logic               ovl_mode,
   input  logic               clr,
   output logic               det_out,
   output logic [CNT_W-1:0]   det_count
);

   localparam int HIST_W = PAT_LEN - 1;
   localparam int FILL_W = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   logic [HIST_W-1:0]  r_hist;
   logic [FILL_W-1:0]  r_fill;

   logic [PAT_LEN-1:0] w_window;
   logic               w_full;
   logic               w_det;

   // Candidate window: stored history followed by the bit on the wire now.
   assign w_window = {r_hist, in_seq};
   assign w_full   = (r_fill == FILL_MAX);

   // rst is included so the pulse drops immediately when reset is asserted,
   // and clr suppresses it because a cleared cycle discards the incoming bit.
   assign w_det   = rst & in_valid & ~clr & w_full & (w_window == pattern);
   assign det_out = w_det;

   // History and fill. The lower HIST_W bits of the window are the shifted
   // history. In non-overlapping mode a detection restarts the fill so the
   // stale history cannot contribute to the next match.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (in_valid) begin
         r_hist <= w_window[HIST_W-1:0];
         if (w_det && !ovl_mode) begin
            r_fill <= '0;
         end else if (!w_full) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] r_count;

   // Saturating counter: holds at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (w_det && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign det_count = r_count;
`else
   assign det_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//
// Three detector instances share one stimulus stream:
//    u_dut3  : PAT_LEN=3,  CNT_W=8
//    u_dut2  : PAT_LEN=2,  CNT_W=2
//    u_dut16 : PAT_LEN=16, CNT_W=8
// A queue-based reference model keeps the accepted bits since the last
// reset/clear/non-overlapping detection and decides matches by comparing the
// tail of that queue against the pattern.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        in_seq;
   logic        ovl_mode;
   logic        clr;
   logic [2:0]  pat3;
   logic [1:0]  pat2;
   logic [15:0] pat16;
   logic        det3, det2, det16;
   logic [7:0]  cnt3;
   logic [1:0]  cnt2;
   logic [7:0]  cnt16;

   seq_detect_param #(.PAT_LEN(3), .CNT_W(8)) u_dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
      .pattern(pat3), .ovl_mode(ovl_mode), .clr(clr),
      .det_out(det3), .det_count(cnt3));

   seq_detect_param #(.PAT_LEN(2), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
      .pattern(pat2), .ovl_mode(ovl_mode), .clr(clr),
      .det_out(det2), .det_count(cnt2));

   seq_detect_param #(.PAT_LEN(16), .CNT_W(8)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
      .pattern(pat16), .ovl_mode(ovl_mode), .clr(clr),
      .det_out(det16), .det_count(cnt16));

   int n_cmp  = 0;
   int n_fail = 0;
   int stepno = 0;

`ifdef SEQ_DET_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", name, stepno, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          mq0[$];
   bit          mq1[$];
   bit          mq2[$];
   int unsigned mc[3];

   function automatic int unsigned cmax(input int k);
      if (!CNT_EN) return 0;
      return (k == 1) ? 3 : 255;
   endfunction

   // Match when at least L-1 bits are stored and the newest L-1 of them plus
   // the incoming bit spell the pattern (pat[L-1] first, pat[0] last).
   function automatic bit q_match(input bit qv[$], input int len, input logic [15:0] pat, input bit s);
      int n;
      n = qv.size();
      if (n < len - 1) return 1'b0;
      if (s != pat[0]) return 1'b0;
      for (int i = 1; i < len; i++)
         if (qv[n-i] != pat[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit exp_det(input int k);
      if (!rst || !in_valid || clr) return 1'b0;
      case (k)
         0:       return q_match(mq0, 3,  {13'd0, pat3}, in_seq);
         1:       return q_match(mq1, 2,  {14'd0, pat2}, in_seq);
         default: return q_match(mq2, 16, pat16,         in_seq);
      endcase
   endfunction

   task automatic model_reset();
      mq0.delete(); mq1.delete(); mq2.delete();
      for (int k = 0; k < 3; k++) mc[k] = 0;
   endtask

   task automatic model_edge();
      bit d[3];
      if (clr) begin
         model_reset();
      end else if (in_valid) begin
         for (int k = 0; k < 3; k++) d[k] = exp_det(k);
         mq0.push_back(in_seq); mq1.push_back(in_seq); mq2.push_back(in_seq);
         if (!ovl_mode) begin
            if (d[0]) mq0.delete();
            if (d[1]) mq1.delete();
            if (d[2]) mq2.delete();
         end
         while (mq0.size() > 16) void'(mq0.pop_front());
         while (mq1.size() > 16) void'(mq1.pop_front());
         while (mq2.size() > 16) void'(mq2.pop_front());
         for (int k = 0; k < 3; k++)
            if (d[k] && mc[k] < cmax(k)) mc[k] = mc[k] + 1;
      end
   endtask

   // Apply one cycle of inputs (entered just after a rising edge), check all
   // outputs mid-cycle, advance the model, and return the sampled pulses.
   task automatic step(input bit v, input bit s, input bit c,
                       output bit d3, output bit d2, output bit d16);
      in_valid = v; in_seq = s; clr = c;
      @(negedge clk);
      stepno++;
      d3 = det3; d2 = det2; d16 = det16;
      check("det3",  32'(det3),  32'(exp_det(0)));
      check("det2",  32'(det2),  32'(exp_det(1)));
      check("det16", 32'(det16), 32'(exp_det(2)));
      check("cnt3",  32'(cnt3),  mc[0]);
      check("cnt2",  32'(cnt2),  mc[1]);
      check("cnt16", 32'(cnt16), mc[2]);
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit v; bit s; bit c; bit ovl; bit exp; bit has_cnt; int cnt_exp;
   } vec_t;

   vec_t tbl[22];

   initial begin
      bit d3, d2, d16;
      logic [15:0] word;

      tbl[0]  = '{1,1,1,1,0,0,0};   // clear, overlapping 101
      tbl[1]  = '{1,1,0,1,0,0,0};
      tbl[2]  = '{1,0,0,1,0,0,0};
      tbl[3]  = '{1,1,0,1,1,0,0};
      tbl[4]  = '{1,0,0,1,0,0,0};
      tbl[5]  = '{1,1,0,1,1,1,2};   // 10101 overlapping: two hits
      tbl[6]  = '{1,0,0,1,0,0,0};   // history now 10, full
      tbl[7]  = '{1,1,1,0,0,1,0};   // clr beats a would-be match
      tbl[8]  = '{1,1,0,0,0,0,0};
      tbl[9]  = '{1,0,0,0,0,0,0};
      tbl[10] = '{1,1,0,0,1,0,0};
      tbl[11] = '{1,0,0,0,0,0,0};
      tbl[12] = '{1,1,0,0,0,1,1};   // 10101 non-overlapping: one hit
      tbl[13] = '{0,0,1,1,0,1,0};
      tbl[14] = '{1,1,0,1,0,0,0};
      tbl[15] = '{1,0,0,1,0,0,0};
      tbl[16] = '{0,1,0,1,0,0,0};   // gap: matching bit but not valid
      tbl[17] = '{0,1,0,1,0,0,0};
      tbl[18] = '{0,1,0,1,0,0,0};
      tbl[19] = '{1,1,0,1,1,1,1};   // gap transparent
      tbl[20] = '{1,0,0,1,0,0,0};
      tbl[21] = '{1,1,0,1,1,1,2};

      // ---- reset state ----
      rst = 1'b0; in_valid = 1'b1; in_seq = 1'b1; clr = 1'b0; ovl_mode = 1'b1;
      pat3 = 3'b101; pat2 = 2'b11; pat16 = 16'hA5C3;
      model_reset();
      #3;
      check("rst_det3", 32'(det3), 32'd0);
      check("rst_det2", 32'(det2), 32'd0);
      check("rst_cnt3", 32'(cnt3), 32'd0);
      check("rst_cnt2", 32'(cnt2), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;                    // release away from the edge
      @(posedge clk); #1;
      check("rel_cnt3", 32'(cnt3), 32'd0);

      // ---- table ----
      for (int i = 0; i < 22; i++) begin
         ovl_mode = tbl[i].ovl;
         step(tbl[i].v, tbl[i].s, tbl[i].c, d3, d2, d16);
         check($sformatf("tbl%0d_det", i), 32'(d3), 32'(tbl[i].exp));
         if (tbl[i].has_cnt)
            check($sformatf("tbl%0d_cnt", i), 32'(cnt3), CNT_EN ? 32'(tbl[i].cnt_exp) : 32'd0);
      end

      // ---- PAT_LEN=2, pattern 11, six ones: five hits, 2-bit counter saturates ----
      ovl_mode = 1'b1;
      step(0, 0, 1, d3, d2, d16);
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 0, d3, d2, d16);
         check($sformatf("ones%0d_det2", i), 32'(d2), (i > 0) ? 32'd1 : 32'd0);
      end
      check("sat_cnt2", 32'(cnt2), CNT_EN ? 32'd3 : 32'd0);
      step(0, 0, 1, d3, d2, d16);
      check("clr_cnt2", 32'(cnt2), 32'd0);

      // ---- PAT_LEN=16, A5C3 MSB first: single pulse on bit 16 ----
      word = 16'hA5C3;
      for (int i = 0; i < 16; i++) begin
         step(1, word[15-i], 0, d3, d2, d16);
         check($sformatf("w16_b%0d", i), 32'(d16), (i == 15) ? 32'd1 : 32'd0);
      end
      check("w16_cnt", 32'(cnt16), CNT_EN ? 32'd1 : 32'd0);

      // ---- randomized run against the model ----
      for (int it = 0; it < 1500; it++) begin
         if ($urandom_range(0, 199) == 0) begin
            for (int b = 0; b < 16; b++) step(1, pat16[15-b], 0, d3, d2, d16);
         end else begin
            bit c;
            c = ($urandom_range(0, 31) == 0);
            if (c) begin
               ovl_mode = 1'($urandom);
               pat3     = 3'($urandom);
               pat2     = 2'($urandom);
            end
            step($urandom_range(0, 3) != 0, 1'($urandom), c, d3, d2, d16);
         end
      end

      // ---- asynchronous reset mid-pattern ----
      ovl_mode = 1'b1; pat3 = 3'b101; pat2 = 2'b11;
      step(0, 0, 1, d3, d2, d16);
      step(1, 1, 0, d3, d2, d16);
      step(1, 0, 0, d3, d2, d16);
      step(1, 1, 0, d3, d2, d16);
      step(1, 0, 0, d3, d2, d16);
      in_valid = 1'b1; in_seq = 1'b1; clr = 1'b0;
      #2;
      check("pre_rst_det3", 32'(det3), 32'd1);
      rst = 1'b0;
      #1;
      check("async_det3",  32'(det3),  32'd0);
      check("async_cnt3",  32'(cnt3),  32'd0);
      check("async_cnt2",  32'(cnt2),  32'd0);
      check("async_cnt16", 32'(cnt16), 32'd0);
      in_valid = 1'b0;
      model_reset();
      @(posedge clk); #2;
      check("hold_det3", 32'(det3), 32'd0);
      rst = 1'b1;
      #1;
      check("release_det3", 32'(det3), 32'd0);
      @(posedge clk); #1;
      check("release_cnt3", 32'(cnt3), 32'd0);
      step(1, 1, 0, d3, d2, d16);
      check("post_rst_bit1", 32'(d3), 32'd0);
      step(1, 0, 0, d3, d2, d16);
      step(1, 1, 0, d3, d2, d16);
      check("post_rst_full", 32'(d3), 32'd1);
      step(0, 0, 0, d3, d2, d16);
      check("post_rst_cnt", 32'(cnt3), CNT_EN ? 32'd1 : 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
